galaga_bullet_scheduler: RTL and testbench

//  Owns the player-bullet slot pool consumed by the GALAGA pixel renderer. Allocates a free slot on a fire

---
 rtl/galaga_bullet_scheduler_pkg.sv | 18 +
 rtl/galaga_bullet_scheduler_if.sv | 30 +++
 rtl/galaga_bullet_scheduler_prienc.sv | 23 ++
 rtl/galaga_bullet_scheduler.sv | 138 +++++++++++++
 tb/tb_galaga_bullet_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/galaga_bullet_scheduler_pkg.sv
// galaga_pkg: shared geometry constants for the GALAGA player-bullet path.
//   X_W/Y_W/POS_W  : coordinate widths; a slot position is {x[9:0], y[8:0]}.
//   DEAD_POSITION  : parking position for retired/unused slots (off-screen).
//   DISPLAY_*      : visible raster size; BULLET_* : bullet sprite size.
package galaga_pkg;
   localparam int unsigned X_W   = 10;
   localparam int unsigned Y_W   = 9;
   localparam int unsigned POS_W = X_W + Y_W;

   localparam logic [X_W-1:0]   DEAD_X        = 10'd720;
   localparam logic [Y_W-1:0]   DEAD_Y        = 9'd500;
   localparam logic [POS_W-1:0] DEAD_POSITION = {DEAD_X, DEAD_Y};

   localparam int unsigned DISPLAY_W = 640;
   localparam int unsigned DISPLAY_H = 480;
   localparam int unsigned BULLET_W  = 2;
   localparam int unsigned BULLET_H  = 8;
endpackage

// File: rtl/galaga_bullet_scheduler_if.sv
// galaga_bullet_scheduler_if: fire/tick handshake and slot-pool view.
//   master : drives frame_tick, fire_req, fire_x, fire_y; observes the rest.
//   slave  : the scheduler; returns fire_ack/fire_drop pulses, slot_pos_flat
//            (slot n at [19n+18:19n]), slot_valid, active_cnt, busy.
interface galaga_bullet_scheduler_if #(
   parameter int unsigned NUM_SLOTS = 16
);
   import galaga_pkg::*;

   logic                       frame_tick;
   logic                       fire_req;
   logic [X_W-1:0]             fire_x;
   logic [Y_W-1:0]             fire_y;
   logic                       fire_ack;
   logic                       fire_drop;
   logic [POS_W*NUM_SLOTS-1:0] slot_pos_flat;
   logic [NUM_SLOTS-1:0]       slot_valid;
   logic [5:0]                 active_cnt;
   logic                       busy;

   modport master (
      output frame_tick, fire_req, fire_x, fire_y,
      input  fire_ack, fire_drop, slot_pos_flat, slot_valid, active_cnt, busy
   );

   modport slave (
      input  frame_tick, fire_req, fire_x, fire_y,
      output fire_ack, fire_drop, slot_pos_flat, slot_valid, active_cnt, busy
   );
endinterface

// File: rtl/galaga_bullet_scheduler_prienc.sv
// galaga_slot_prienc: combinational lowest-index priority encoder.
//   free_mask : one bit per slot, 1 = slot available
//   idx       : lowest set index (0 when none)
//   any       : at least one bit set
module galaga_slot_prienc #(
   parameter int unsigned N     = 16,
   parameter int unsigned IDX_W = 4
) (
   input  logic [N-1:0]     free_mask,
   output logic [IDX_W-1:0] idx,
   output logic             any
);
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (free_mask[i] && !any) begin
            idx = IDX_W'(i);
            any = 1'b1;
         end
      end
   end
endmodule

// File: rtl/galaga_bullet_scheduler.sv
// galaga_bullet_scheduler: player-bullet slot pool for the pixel renderer.
//   i_Clk, i_Rst : pixel clock, asynchronous active-high reset
//   bus (slave)  : frame_tick pulse, fire_req/fire_x/fire_y level request,
//                  fire_ack/fire_drop pulses, slot_pos_flat, slot_valid,
//                  active_cnt, busy (FSM not IDLE)
// IDLE allocates on fire or starts a one-slot-per-cycle SCAN on a pending
// frame tick (tick wins); RESP is the one-cycle ack/drop response state.
// Optional macro GALAGA_FIRE_COOLDOWN_EN: refuse fires until COOLDOWN_FRAMES
// frame ticks have elapsed since the last accepted fire.
module galaga_bullet_scheduler
   import galaga_pkg::*;
#(
   parameter int unsigned NUM_SLOTS       = 16,
   parameter int unsigned STEP_Y          = 4,
   parameter int unsigned COOLDOWN_FRAMES = 8
) (
   input  logic                           i_Clk,
   input  logic                           i_Rst,
   galaga_bullet_scheduler_if.slave       bus
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam int unsigned    IDX_W = $clog2(NUM_SLOTS);
   localparam logic [Y_W-1:0] STEP  = Y_W'(STEP_Y);

   if (NUM_SLOTS < 2 || NUM_SLOTS > 32 || STEP_Y == 0 || STEP_Y > 511 ||
       COOLDOWN_FRAMES == 0) begin : g_bad_param
      $error("galaga_bullet_scheduler: parameter out of range");
   end

   logic [1:0]       state;
   logic [IDX_W-1:0] idx;
   logic             tick_pend;
   logic [POS_W-1:0] pos [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] valid;
   logic [5:0]       cnt;
   logic             ack;
   logic             drop;
   logic [IDX_W-1:0] free_idx;
   logic             any_free;
   logic             tick_now;
   logic             fire_ok;

   galaga_slot_prienc #(
      .N     (NUM_SLOTS),
      .IDX_W (IDX_W)
   ) u_prienc (
      .free_mask (~valid),
      .idx       (free_idx),
      .any       (any_free)
   );

   // A tick arriving in the IDLE cycle itself must still beat a same-cycle fire.
   assign tick_now = tick_pend | bus.frame_tick;

`ifdef GALAGA_FIRE_COOLDOWN_EN
   localparam int unsigned CD_W = $clog2(COOLDOWN_FRAMES + 1);
   logic [CD_W-1:0] cd_cnt;
   assign fire_ok = any_free && (cd_cnt == '0);
`else
   assign fire_ok = any_free;
`endif

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state     <= ST_IDLE;
         idx       <= '0;
         tick_pend <= 1'b0;
         valid     <= '0;
         cnt       <= '0;
         ack       <= 1'b0;
         drop      <= 1'b0;
         for (int unsigned i = 0; i < NUM_SLOTS; i++) pos[i] <= DEAD_POSITION;
`ifdef GALAGA_FIRE_COOLDOWN_EN
         cd_cnt    <= '0;
`endif
      end else begin
         ack  <= 1'b0;
         drop <= 1'b0;
         if (bus.frame_tick) tick_pend <= 1'b1;
`ifdef GALAGA_FIRE_COOLDOWN_EN
         if (bus.frame_tick && cd_cnt != '0) cd_cnt <= cd_cnt - 1'b1;
`endif
         case (state)
            ST_IDLE: begin
               if (tick_now) begin
                  // Overrides the set above: this tick is consumed by the scan.
                  tick_pend <= 1'b0;
                  idx       <= '0;
                  state     <= ST_SCAN;
               end else if (bus.fire_req) begin
                  if (fire_ok) begin
                     pos[free_idx]   <= {bus.fire_x, bus.fire_y};
                     valid[free_idx] <= 1'b1;
                     cnt             <= cnt + 6'd1;
                     ack             <= 1'b1;
`ifdef GALAGA_FIRE_COOLDOWN_EN
                     cd_cnt          <= CD_W'(COOLDOWN_FRAMES);
`endif
                  end else begin
                     drop <= 1'b1;
                  end
                  state <= ST_RESP;
               end
            end
            ST_SCAN: begin
               if (valid[idx]) begin
                  if (pos[idx][Y_W-1:0] < STEP) begin
                     pos[idx]   <= DEAD_POSITION;
                     valid[idx] <= 1'b0;
                     cnt        <= cnt - 6'd1;
                  end else begin
                     pos[idx][Y_W-1:0] <= pos[idx][Y_W-1:0] - STEP;
                  end
               end
               if (idx == IDX_W'(NUM_SLOTS - 1)) state <= ST_IDLE;
               else                              idx   <= idx + IDX_W'(1);
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.slot_pos_flat = '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++)
         bus.slot_pos_flat[i*POS_W +: POS_W] = pos[i];
   end

   assign bus.slot_valid = valid;
   assign bus.active_cnt = cnt;
   assign bus.fire_ack   = ack;
   assign bus.fire_drop  = drop;
   assign bus.busy       = (state != ST_IDLE);
endmodule

// File: tb/tb_galaga_bullet_scheduler.sv
// Scoreboard bench for galaga_bullet_scheduler. Each issued fire/tick updates
// a slot-array model and queues the expected pool snapshot; a negedge monitor
// pops and compares on every ack/drop pulse and at the end of every scan.
// Honours GALAGA_FIRE_COOLDOWN_EN like the design.
module tb_galaga_bullet_scheduler;
   import galaga_pkg::*;

   localparam int unsigned N  = 16;
   localparam int unsigned ST = 4;
   localparam int unsigned CD = 8;
   localparam int unsigned FW = POS_W * N;

   typedef struct {
      int            kind;   // 0 ack, 1 drop, 2 scan end
      logic [FW-1:0] flat;
      logic [N-1:0]  valid;
      int            cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   galaga_bullet_scheduler_if #(.NUM_SLOTS(N)) bus ();

   galaga_bullet_scheduler #(
      .NUM_SLOTS       (N),
      .STEP_Y          (ST),
      .COOLDOWN_FRAMES (CD)
   ) dut (
      .i_Clk (clk),
      .i_Rst (rst),
      .bus   (bus)
   );

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   mx[N];
   int   my[N];
   bit   mv[N];
   int   ticks_since_ack;
   int   busy_run = 0;

   task automatic check_int(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic check_vec(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mx[i] = 720; my[i] = 500; mv[i] = 0;
      end
      ticks_since_ack = 1000;
   endtask

   task automatic model_push(input int kind);
      exp_t e;
      e.kind = kind; e.flat = '0; e.valid = '0; e.cnt = 0;
      for (int i = 0; i < N; i++) begin
         e.flat[i*POS_W +: POS_W] = {10'(mx[i]), 9'(my[i])};
         e.valid[i] = mv[i];
         e.cnt += mv[i] ? 1 : 0;
      end
      q.push_back(e);
   endtask

   // One scan: every live bullet moves up STEP, or dies if it would leave the top.
   task automatic model_scan();
      for (int i = 0; i < N; i++) begin
         if (mv[i]) begin
            if (my[i] < ST) begin mx[i] = 720; my[i] = 500; mv[i] = 0; end
            else my[i] = my[i] - ST;
         end
      end
      model_push(2);
   endtask

   task automatic model_fire(input int x, input int y);
      int slot = -1;
      bit ok;
      for (int i = N - 1; i >= 0; i--) if (!mv[i]) slot = i;
      ok = (slot >= 0);
`ifdef GALAGA_FIRE_COOLDOWN_EN
      if (ticks_since_ack < CD) ok = 0;
`endif
      if (ok) begin
         mx[slot] = x; my[slot] = y; mv[slot] = 1;
         ticks_since_ack = 0;
         model_push(0);
      end else begin
         model_push(1);
      end
   endtask

   function automatic bit model_full();
      model_full = 1;
      for (int i = 0; i < N; i++) if (!mv[i]) model_full = 0;
   endfunction

   // ---------------- monitor ----------------
   task automatic observe(input int kind, input int run);
      exp_t e;
      if (q.size() == 0) begin
         checks++; errors++;
         $display("FAIL unexpected_event kind=%0d with empty scoreboard", kind);
      end else begin
         e = q.pop_front();
         check_int("event_kind", kind, e.kind);
         if (kind == 2) check_int("scan_busy_cycles", run, N);
         check_vec("slot_pos", bus.slot_pos_flat, e.flat);
         check_int("slot_valid", bus.slot_valid, e.valid);
         check_int("active_cnt", bus.active_cnt, e.cnt);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         busy_run = 0;
      end else begin
         if (bus.busy) busy_run++;
         else begin
            if (busy_run >= 2) observe(2, busy_run);
            busy_run = 0;
         end
         if (bus.fire_ack && bus.fire_drop) begin
            checks++; errors++;
            $display("FAIL ack_and_drop both high");
         end else if (bus.fire_ack) observe(0, 0);
         else if (bus.fire_drop) observe(1, 0);
      end
   end

   // ---------------- driver ----------------
   task automatic wait_idle();
      int idle = 0;
      int n = 0;
      while (n < 200 && !(idle >= 2 && q.size() == 0)) begin
         @(negedge clk);
         n++;
         idle = bus.busy ? 0 : idle + 1;
      end
      if (n >= 200) begin
         checks++; errors++;
         $display("FAIL wait_idle timeout busy=%0d pending=%0d", bus.busy, q.size());
         q.delete();
      end
   endtask

   task automatic wait_resp(input bit check_lat);
      int n = 0;
      bit got = 0;
      while (n < 64 && !got) begin
         @(negedge clk);
         n++;
         if (bus.fire_ack || bus.fire_drop) got = 1;
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL fire_response timeout actual=none expected=ack_or_drop");
      end else if (check_lat) check_int("fire_latency", n, 2);
      @(posedge clk); #1;
      bus.fire_req = 1'b0;
   endtask

   task automatic do_fire(input int x, input int y, input bit check_lat);
      @(posedge clk); #1;
      bus.fire_req = 1'b1; bus.fire_x = 10'(x); bus.fire_y = 9'(y);
      model_fire(x, y);
      wait_resp(check_lat);
      wait_idle();
   endtask

   task automatic raw_tick();
      @(posedge clk); #1;
      bus.frame_tick = 1'b1;
      ticks_since_ack++;
      @(posedge clk); #1;
      bus.frame_tick = 1'b0;
   endtask

   task automatic do_tick();
      raw_tick();
      model_scan();
      wait_idle();
   endtask

   task automatic do_tick_fire(input int x, input int y);
      @(posedge clk); #1;
      bus.frame_tick = 1'b1; bus.fire_req = 1'b1;
      bus.fire_x = 10'(x); bus.fire_y = 9'(y);
      ticks_since_ack++;
      model_scan();
      model_fire(x, y);
      @(posedge clk); #1;
      bus.frame_tick = 1'b0;
      wait_resp(1'b0);
      wait_idle();
   endtask

   // First tick starts a scan; two more during it coalesce into one extra scan.
   task automatic do_double_tick();
      raw_tick();
      model_scan();
      repeat (3) @(posedge clk);
      raw_tick();
      repeat (3) @(posedge clk);
      raw_tick();
      model_scan();
      wait_idle();
   endtask

   task automatic check_reset_state();
      logic [FW-1:0] dead = '0;
      for (int i = 0; i < N; i++) dead[i*POS_W +: POS_W] = {10'd720, 9'd500};
      @(negedge clk);
      check_vec("reset_pos", bus.slot_pos_flat, dead);
      check_int("reset_valid", bus.slot_valid, 0);
      check_int("reset_cnt", bus.active_cnt, 0);
      check_int("reset_busy", bus.busy, 0);
      check_int("reset_ack", bus.fire_ack, 0);
      check_int("reset_drop", bus.fire_drop, 0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      bus.frame_tick = 1'b0; bus.fire_req = 1'b0;
      q.delete();
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check_reset_state();
   endtask

   initial begin
      int r;
      bus.frame_tick = 1'b0; bus.fire_req = 1'b0;
      bus.fire_x = '0; bus.fire_y = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_reset_state();

      do_fire(200, 372, 1'b1);
      do_fire(64, 300, 1'b1);
      do_fire(50, 3, 1'b1);
      do_tick();
      do_double_tick();
      do_tick_fire(10, 100);

`ifndef GALAGA_FIRE_COOLDOWN_EN
      while (!model_full()) do_fire(int'($urandom_range(0, 1023)), int'($urandom_range(200, 511)), 1'b1);
      do_fire(333, 222, 1'b1);
      do_tick_fire(7, 77);
`endif

      for (int k = 0; k < 80; k++) begin
         r = int'($urandom_range(0, 9));
         if (r <= 5)
            do_fire(int'($urandom_range(0, 1023)),
                    ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 511)),
                    1'b1);
         else if (r <= 7) do_tick();
         else if (r == 8) do_double_tick();
         else do_tick_fire(int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)));
      end

      // Reset partway through a scan must leave nothing of it behind.
      do_fire(300, 200, 1'b0);
      raw_tick();
      repeat (5) @(negedge clk);
      check_int("busy_mid_scan", bus.busy, 1);
      do_reset();

`ifdef GALAGA_FIRE_COOLDOWN_EN
      do_fire(100, 400, 1'b1);
      repeat (3) do_tick();
      do_fire(110, 400, 1'b1);
      repeat (5) do_tick();
      do_fire(120, 400, 1'b1);
`endif

      wait_idle();
      check_int("scoreboard_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
